// File: rtl/lfsr_rand_arbiter_if.sv
// ============================================================================
//  Module      : lfsr_rand_arbiter_if
//  Description : Bundle of request/grant, random-word and LFSR control
//                signals between lfsr_rand_arbiter and its environment.
//                master : requesters + LFSR side (drive req, lfsr_q)
//                slave  : the arbiter itself
//                Optional LFSR_ARB_RESEED_EN adds reseed / reseed_value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_rand_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int OUT_W   = 8
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               rnd_valid;
    logic [OUT_W-1:0]   rnd_data;
    logic               busy;
    logic [7:0]         lfsr_seed;
    logic               lfsr_load;
    logic               lfsr_q;
`ifdef LFSR_ARB_RESEED_EN
    logic               reseed;
    logic [7:0]         reseed_value;
`endif

    modport master (
        output req,
        output lfsr_q,
`ifdef LFSR_ARB_RESEED_EN
        output reseed,
        output reseed_value,
`endif
        input  gnt,
        input  rnd_valid,
        input  rnd_data,
        input  busy,
        input  lfsr_seed,
        input  lfsr_load
    );

    modport slave (
        input  req,
        input  lfsr_q,
`ifdef LFSR_ARB_RESEED_EN
        input  reseed,
        input  reseed_value,
`endif
        output gnt,
        output rnd_valid,
        output rnd_data,
        output busy,
        output lfsr_seed,
        output lfsr_load
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_rand_arbiter.sv
// ============================================================================
//  Module      : lfsr_rand_arbiter
//  Description : Shares one serial 8-bit LFSR between NUM_REQ requesters.
//                After reset it seeds and warms the LFSR (8 discarded bits),
//                then per request gathers OUT_W serial bits (first bit in the
//                MSB) and delivers the word with a one-cycle one-hot grant to
//                the round-robin winner.
//  Ports       : clk            system clock, rising edge
//                rst            asynchronous active-low reset
//                bus (slave)    req/gnt/rnd_valid/rnd_data/busy,
//                               lfsr_seed/lfsr_load/lfsr_q
//                               (+ reseed/reseed_value)
//  Macro       : LFSR_ARB_RESEED_EN - enables run-time reseeding
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_rand_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter int         OUT_W   = 8,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lfsr_rand_arbiter_if.slave bus
);

    localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int         SUM_W    = IDX_W + 1;
    localparam int         CNT_W    = 5;
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [SUM_W-1:0] NREQ_C    = SUM_W'(NUM_REQ);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] GATH_LAST = CNT_W'(OUT_W - 1);

    typedef enum logic [2:0] {
        ST_SEED    = 3'd0,
        ST_WARM    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_GATHER  = 3'd3,
        ST_DELIVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   win_q,   win_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [OUT_W-1:0]   shreg_q, shreg_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   data_q,  data_d;
    logic               load_q,  load_d;
    logic [7:0]         seed_q,  seed_d;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_win;
    logic [SUM_W-1:0]   rr_sum;

    // Round-robin search: first asserted request strictly after the pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_sum   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (rr_sum >= NREQ_C) begin
                rr_sum = rr_sum - NREQ_C;
            end
            if (!rr_found && bus.req[rr_sum[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        load_d  = 1'b0;
        seed_d  = seed_q;

        case (state_q)
            ST_SEED: begin
                load_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_WARM;
            end
            ST_WARM: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rr_found) begin
                    win_d   = rr_win;
                    cnt_d   = '0;
                    state_d = ST_GATHER;
                end
            end
            ST_GATHER: begin
                shreg_d = {shreg_q[OUT_W-2:0], bus.lfsr_q};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == GATH_LAST) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                // Outputs are registered here so a same-cycle reseed can
                // still suppress the grant.
                gnt_d[win_q] = 1'b1;
                valid_d      = 1'b1;
                data_d       = shreg_q;
                ptr_d        = win_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_SEED;
            end
        endcase

`ifdef LFSR_ARB_RESEED_EN
        // Reseed overrides everything: in-flight word dropped, pointer kept.
        if (bus.reseed) begin
            state_d = ST_SEED;
            seed_d  = (bus.reseed_value == 8'h00) ? 8'h01 : bus.reseed_value;
            gnt_d   = '0;
            valid_d = 1'b0;
            data_d  = data_q;
            ptr_d   = ptr_q;
            cnt_d   = '0;
            load_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SEED;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            load_q  <= 1'b0;
            seed_q  <= SEED_EFF;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            load_q  <= load_d;
            seed_q  <= seed_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = valid_q;
    assign bus.rnd_data  = data_q;
    assign bus.lfsr_load = load_q;
    assign bus.lfsr_seed = seed_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rand_arbiter.sv
// ============================================================================
//  Module      : tb_lfsr_rand_arbiter
//  Description : Self-checking bench for lfsr_rand_arbiter. A timeline model
//                (edge numbers, next free sample edge, scheduled grant edge)
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_rand_arbiter;

    localparam int         NUM_REQ = 4;
    localparam int         OUT_W   = 8;
    localparam logic [7:0] SEED    = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_rand_arbiter_if #(.NUM_REQ(NUM_REQ), .OUT_W(OUT_W)) bus ();

    lfsr_rand_arbiter #(
        .NUM_REQ (NUM_REQ),
        .OUT_W   (OUT_W),
        .SEED    (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus state
    logic [NUM_REQ-1:0] req_v;
    logic               bit_v;
    logic               hold_req;
`ifdef LFSR_ARB_RESEED_EN
    logic               reseed_v;
    logic [7:0]         reseed_val_v;
`endif

    // Reference model state: positions on a timeline of rising edges
    int                 edge_n;
    int                 next_free;   // first edge at which IDLE can sample req
    int                 sched;       // edge at which the grant appears (-1 none)
    int                 gath_start;  // edge where the current request was taken
    int                 load_edge;
    int                 last_ptr;
    int                 win_idx;
    int                 g_edge;
    logic [NUM_REQ-1:0] exp_gnt;
    logic               exp_valid;
    logic               exp_busy;
    logic               exp_load;
    logic [OUT_W-1:0]   word;
    logic [OUT_W-1:0]   last_data;
    logic [7:0]         exp_seed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic model_reset();
        edge_n    = 0;
        next_free = 10;
        sched     = -1;
        gath_start = 0;
        load_edge = 1;
        last_ptr  = NUM_REQ - 1;
        win_idx   = 0;
        exp_gnt   = '0;
        exp_valid = 1'b0;
        exp_busy  = 1'b1;
        exp_load  = 1'b0;
        word      = '0;
        last_data = '0;
        exp_seed  = (SEED == 8'h00) ? 8'h01 : SEED;
    endtask

    task automatic model_edge();
        bit found;
        int idx;
        exp_gnt   = '0;
        exp_valid = 1'b0;
        if (sched >= 0 && edge_n > gath_start && edge_n <= gath_start + OUT_W) begin
            word = word | (OUT_W'(bit_v) << (OUT_W - 1 - (edge_n - gath_start - 1)));
        end
`ifdef LFSR_ARB_RESEED_EN
        if (reseed_v) begin
            sched     = -1;
            load_edge = edge_n + 1;
            next_free = edge_n + 10;
            exp_seed  = (reseed_val_v == 8'h00) ? 8'h01 : reseed_val_v;
        end else
`endif
        if (edge_n == sched) begin
            exp_gnt   = NUM_REQ'(1) << win_idx;
            exp_valid = 1'b1;
            last_data = word;
            last_ptr  = win_idx;
            sched     = -1;
        end
        if (edge_n >= next_free && req_v != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (last_ptr + k) % NUM_REQ;
                if (!found && req_v[idx]) begin
                    found   = 1'b1;
                    win_idx = idx;
                end
            end
            gath_start = edge_n;
            sched      = edge_n + OUT_W + 1;
            next_free  = edge_n + OUT_W + 2;
            word       = '0;
        end
        exp_load = (edge_n == load_edge);
        exp_busy = (edge_n < next_free - 1);
    endtask

    // Drive inputs at a falling edge, advance one rising edge, check outputs
    // at the next falling edge, then let requesters react to the grant.
    task automatic step();
        bus.req    = req_v;
        bus.lfsr_q = bit_v;
`ifdef LFSR_ARB_RESEED_EN
        bus.reseed       = reseed_v;
        bus.reseed_value = reseed_val_v;
`endif
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        chk("gnt",       32'(bus.gnt),       32'(exp_gnt));
        chk("rnd_valid", 32'(bus.rnd_valid), 32'(exp_valid));
        chk("rnd_data",  32'(bus.rnd_data),  32'(last_data));
        chk("busy",      32'(bus.busy),      32'(exp_busy));
        chk("lfsr_load", 32'(bus.lfsr_load), 32'(exp_load));
        chk("lfsr_seed", 32'(bus.lfsr_seed), 32'(exp_seed));
        if (!hold_req) begin
            req_v = req_v & ~exp_gnt;
        end
        bit_v = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt),       32'(0));
        chk({tag, "_valid"}, 32'(bus.rnd_valid), 32'(0));
        chk({tag, "_data"},  32'(bus.rnd_data),  32'(0));
        chk({tag, "_load"},  32'(bus.lfsr_load), 32'(0));
        chk({tag, "_seed"},  32'(bus.lfsr_seed), 32'(SEED));
        chk({tag, "_busy"},  32'(bus.busy),      32'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        req_v = '0;
        while (exp_busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 1;
        step();
        while (!bus.rnd_valid && n < 40) begin
            step();
            n++;
        end
        if (!bus.rnd_valid) begin
            chk({tag, "_timeout"}, 32'(bus.rnd_valid), 32'(1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        req_v    = '0;
        bit_v    = 1'b0;
        hold_req = 1'b0;
        bus.req    = '0;
        bus.lfsr_q = 1'b0;
`ifdef LFSR_ARB_RESEED_EN
        reseed_v         = 1'b0;
        reseed_val_v     = 8'h00;
        bus.reseed       = 1'b0;
        bus.reseed_value = 8'h00;
`endif
        model_reset();

        // Reset and seed/warm-up sequence
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (9) step();

        // Single word with a known bit pattern
        pat   = 8'hA5;
        req_v = 4'b0100;
        step();
        for (int i = 0; i < OUT_W; i++) begin
            bit_v = pat[OUT_W-1-i];
            step();
        end
        step();
        chk("single_gnt",  32'(bus.gnt),      32'(4'b0100));
        chk("single_data", 32'(bus.rnd_data), 32'(8'hA5));
        g_edge = edge_n;

        // Round-robin with every requester held high
        hold_req = 1'b1;
        req_v    = '1;
        for (int g = 1; g <= 8; g++) begin
            wait_grant("rr");
            chk("rr_order",   32'(bus.gnt),       32'(1) << ((2 + g) % NUM_REQ));
            chk("rr_spacing", 32'(edge_n - g_edge), 32'(OUT_W + 2));
            g_edge = edge_n;
        end
        hold_req = 1'b0;

        // Request dropped mid-GATHER, another requester pending
        wait_idle();
        req_v = 4'b0001;
        step();
        repeat (3) step();
        req_v = 4'b0100;
        wait_grant("drop");
        chk("drop_gnt", 32'(bus.gnt), 32'(4'b0001));
        wait_grant("drop_next");
        chk("drop_next_gnt", 32'(bus.gnt), 32'(4'b0100));

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    req_v[i] = 1'b1;
                end
            end
            step();
        end

        // Asynchronous reset in the middle of GATHER
        wait_idle();
        req_v = 4'b0010;
        step();
        repeat (4) step();
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async");
        req_v   = '0;
        bus.req = '0;
        @(negedge clk);
        check_reset_values("async_hold");
        rst = 1'b1;
        model_reset();
        repeat (12) step();
        req_v = 4'b0001;
        wait_grant("post_reset");
        chk("post_reset_gnt", 32'(bus.gnt), 32'(4'b0001));

`ifdef LFSR_ARB_RESEED_EN
        // Reseed with a zero value in the middle of GATHER
        wait_idle();
        req_v = 4'b0010;
        step();
        repeat (3) step();
        reseed_v     = 1'b1;
        reseed_val_v = 8'h00;
        step();
        reseed_v = 1'b0;
        step();
        chk("reseed_load", 32'(bus.lfsr_load), 32'(1));
        chk("reseed_seed", 32'(bus.lfsr_seed), 32'(8'h01));
        wait_grant("reseed");
        chk("reseed_gnt", 32'(bus.gnt), 32'(4'b0010));
`endif

        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lfsr_rand_arbiter.md
# lfsr_rand_arbiter

Sequencer and round-robin arbiter that shares the single 8-bit serial `lfsr` random-bit generator among several game-logic requesters, such as fruit spawn position, fruit type and spawn timing.
- After reset it loads and warms up the LFSR.
- Per request, it gathers `OUT_W` consecutive serial bits into a parallel word and hands that word to exactly one requester.
- It sits between the `lfsr` instance and the spawn/game controllers.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `OUT_W`, 8, bits per delivered random word (2..16)
- `SEED`, 8'hA5, power-up LFSR seed; a value of 0 is replaced by 8'h01

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request level; held until its `gnt`
- `gnt`  out  NUM_REQ  one-hot grant pulse, one cycle, coincident with `rnd_valid`
- `rnd_valid`  out  1  `rnd_data` valid this cycle
- `rnd_data`  out  OUT_W  random word for the granted requester
- `busy`  out  1  high whenever state is not IDLE
- `lfsr_seed`  out  8  seed to LFSR
- `lfsr_load`  out  1  one-cycle pulse that loads `lfsr_seed` into the LFSR
- `lfsr_q`  in  1  LFSR serial output; one new bit per clock when `lfsr_load` is low
- `reseed`  in  1  (only with `LFSR_ARB_RESEED_EN`) reseed request pulse
- `reseed_value`  in  8  (only with `LFSR_ARB_RESEED_EN`) new seed

## Operation
States are SEED, WARM, IDLE, GATHER and DELIVER.
- **Reset values:** state=SEED; `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `lfsr_load`=0, `lfsr_seed`=SEED (0→8'h01); rr pointer=NUM_REQ-1; bit counter=0; shift reg=0; `busy`=1.
- **SEED:** `lfsr_load`=1 for exactly one cycle, then go to WARM.
- **WARM:** discard 8 `lfsr_q` bits (8 cycles), then go to IDLE.
- **IDLE:** if `req` is nonzero, pick the winner by round-robin starting at pointer+1 (wrapping), latch the winner index, clear the counter and go to GATHER. If `req` is 0, stay in IDLE.
- **GATHER:** each cycle, `shreg <= {shreg[OUT_W-2:0], lfsr_q}` (first bit ends up in the MSB). After OUT_W bits, go to DELIVER.
- **DELIVER:**
  - For one cycle: `gnt[winner]`=1, `rnd_valid`=1, `rnd_data`=shreg.
  - Pointer becomes the winner.
  - Next state is IDLE.
- `rnd_data` holds its last value while `rnd_valid`=0.
- Requests arriving during GATHER or DELIVER wait for the next IDLE.
- If a requester drops `req` mid-GATHER, the word is still delivered and `gnt` is still pulsed to it. Its owner ignores the grant.
- Each bit is used once: no LFSR bit is delivered to two requesters.
- **Reset mid-operation:** asynchronous return to all reset values. Any in-flight word is lost and no `gnt` is issued.

## Timing
- A `req` sampled high in IDLE at edge t gives `gnt` and `rnd_valid` during cycle t+OUT_W+1.
- Minimum spacing between grants is OUT_W+2 cycles (one IDLE cycle, OUT_W GATHER cycles, one DELIVER cycle).
- First grant after reset release is possible no earlier than 1+8+1+OUT_W+1 cycles.
- **Fairness:** with all requesters held high, grants rotate 0,1,…,NUM_REQ-1,0.
- `gnt` is never multi-hot, and `gnt` is never high without `rnd_valid`.

## Configuration
- `LFSR_ARB_RESEED_EN` defined:
  - Adds the `reseed` and `reseed_value` ports.
  - A `reseed` pulse in any state forces SEED next cycle, with `lfsr_seed`=`reseed_value` (0→8'h01).
  - Any GATHER is aborted with no grant.
  - If `reseed` coincides with DELIVER, reseed wins and no `gnt` is issued.
  - The rr pointer is unchanged.
- Not defined: the ports are absent, and the seed is loaded only after reset, from `SEED`.

## Test plan
- **Reset/seed:** release `rst`. Expect `lfsr_load` high exactly one cycle, with `lfsr_seed`=8'hA5. Expect `busy` low after 10 cycles. Expect `gnt`=0 throughout.
- **Single word:** bench drives `lfsr_q` as 1,0,1,0,0,1,0,1 during GATHER and raises `req`=4'b0100 in IDLE. Expect `rnd_data`=8'hA5 and `gnt`=4'b0100 exactly OUT_W+1 cycles after the IDLE sample.
- **Round-robin:** hold `req`=4'b1111 for 8 grants. Expect the `gnt` sequence 0001,0010,0100,1000,0001,… with a spacing of 10 cycles.
- **Request drop:** set `req`=4'b0001 and drop it 3 cycles into GATHER. Expect `gnt`=4'b0001 still delivered. The next grant goes to a requester other than 0 if one is pending.
- **Async reset mid-GATHER:** assert `rst` low at GATHER bit 4. Expect all outputs at reset values immediately, no `gnt`, and the SEED sequence repeated on release.
- **Reseed (macro on):** pulse `reseed` with `reseed_value`=8'h00 mid-GATHER. Expect no `gnt`, `lfsr_load` pulse with `lfsr_seed`=8'h01, and normal service resuming after WARM.
